// File: rtl/ex_pkg.sv
// Shared encodings for the EX stage: ALU and multiply/divide op codes,
// forwarding selects, destination selects and the mul/div FSM states.
package ex_pkg;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_NOR  = 4'd5;
   localparam logic [3:0] ALU_SLT  = 4'd6;
   localparam logic [3:0] ALU_SLTU = 4'd7;
   localparam logic [3:0] ALU_SLL  = 4'd8;
   localparam logic [3:0] ALU_SRL  = 4'd9;
   localparam logic [3:0] ALU_SRA  = 4'd10;
   localparam logic [3:0] ALU_LUI  = 4'd11;
   localparam logic [3:0] ALU_MFHI = 4'd12;
   localparam logic [3:0] ALU_MFLO = 4'd13;

   localparam logic [2:0] MD_NONE  = 3'd0;
   localparam logic [2:0] MD_MULT  = 3'd1;
   localparam logic [2:0] MD_MULTU = 3'd2;
   localparam logic [2:0] MD_DIV   = 3'd3;
   localparam logic [2:0] MD_DIVU  = 3'd4;

   localparam logic [1:0] FWD_ID     = 2'b00;
   localparam logic [1:0] FWD_MEM    = 2'b01;
   localparam logic [1:0] FWD_WB     = 2'b10;
   localparam logic [1:0] FWD_ID_ALT = 2'b11;

   localparam logic [1:0] REG_DST_RT = 2'b00;
   localparam logic [1:0] REG_DST_RD = 2'b01;
   localparam logic [1:0] REG_DST_RA = 2'b10;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_RUN  = 2'd1,
      MD_DONE = 2'd2
   } md_state_t;

   // Any code outside the four defined operations is treated as "no operation".
   function automatic logic is_md_op(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic is_md_signed(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/execute_stage_mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO. Works on operand magnitudes for
// MD_CYCLES iterations (shift-add or restoring division), fixes signs and
// writes HI/LO in a final DONE cycle. Everything freezes while i_halt is high.
module mul_div_unit
   import ex_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MD_CYCLES  = 32
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_halt,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  busy,
   output logic [DATA_WIDTH-1:0] hi,
   output logic [DATA_WIDTH-1:0] lo
);

   localparam int W     = DATA_WIDTH;
   localparam int CNT_W = $clog2(MD_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_CYCLES - 1);

   // Magnitude of an operand; unsigned ops pass through untouched.
   function automatic logic [W-1:0] magnitude(input logic signed [W-1:0] v, input logic sgn);
      return (sgn && v[W-1]) ? $unsigned(-v) : $unsigned(v);
   endfunction

   function automatic logic [2*W-1:0] sign_fix_wide(input logic [2*W-1:0] v, input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [W-1:0] sign_fix(input logic [W-1:0] v, input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

   md_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       op_q;
   logic [W-1:0]     dvd_q;
   logic [W-1:0]     mag_b_q;
   logic [2*W-1:0]   acc_q;
   logic             neg_res_q, neg_rem_q;
   logic [W-1:0]     hi_q, lo_q;

   logic             start_ok, op_signed, div_q;
   logic [W-1:0]     mag_a, mag_b;
   logic [W:0]       sum_w, shl_w;
   logic [W-1:0]     diff_w;
   logic             take_w;
   logic [2*W-1:0]   acc_step, prod_w;
   logic [W-1:0]     hi_res, lo_res;

   assign start_ok  = start & is_md_op(op);
   assign op_signed = is_md_signed(op);
   assign mag_a     = magnitude($signed(a), op_signed);
   assign mag_b     = magnitude($signed(b), op_signed);
   assign div_q     = (op_q == MD_DIV) || (op_q == MD_DIVU);

   // FSM state register; halt freezes it.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= MD_IDLE;
      end else if (!i_halt) begin
         state_q <= state_d;
      end
   end

   // FSM next state: IDLE -> RUN for MD_CYCLES iterations -> DONE -> IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         MD_IDLE: if (start_ok) state_d = MD_RUN;
         MD_RUN:  if (cnt_q == CNT_LAST) state_d = MD_DONE;
         MD_DONE: state_d = MD_IDLE;
         default: state_d = MD_IDLE;
      endcase
   end

   // FSM outputs: the unit is busy until HI/LO have been written.
   always_comb begin
      busy = (state_q == MD_RUN) || (state_q == MD_DONE);
   end

   // One iteration: acc holds {partial, multiplier} or {remainder, quotient}.
   always_comb begin
      sum_w  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mag_b_q} : {(W+1){1'b0}});
      shl_w  = {acc_q[2*W-1:W], acc_q[W-1]};
      take_w = (shl_w >= {1'b0, mag_b_q});
      diff_w = shl_w[W-1:0] - mag_b_q;
      if (div_q) begin
         acc_step = {(take_w ? diff_w : shl_w[W-1:0]), acc_q[W-2:0], take_w};
      end else begin
         acc_step = {sum_w, acc_q[W-1:1]};
      end
   end

   // Sign correction and the divide-by-zero convention applied in DONE.
   always_comb begin
      prod_w = sign_fix_wide(acc_q, neg_res_q);
      hi_res = prod_w[2*W-1:W];
      lo_res = prod_w[W-1:0];
      if (div_q) begin
         if (mag_b_q == '0) begin
            lo_res = '1;
            hi_res = dvd_q;
         end else begin
            lo_res = sign_fix(acc_q[W-1:0], neg_res_q);
            hi_res = sign_fix(acc_q[2*W-1:W], neg_rem_q);
         end
      end
   end

   // Operand capture, iteration counter/accumulator and HI/LO write-back.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cnt_q     <= '0;
         op_q      <= MD_NONE;
         dvd_q     <= '0;
         mag_b_q   <= '0;
         acc_q     <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else if (!i_halt) begin
         case (state_q)
            MD_IDLE: begin
               if (start_ok) begin
                  op_q      <= op;
                  dvd_q     <= a;
                  mag_b_q   <= mag_b;
                  acc_q     <= {{W{1'b0}}, mag_a};
                  neg_res_q <= op_signed & (a[W-1] ^ b[W-1]);
                  neg_rem_q <= op_signed & a[W-1];
                  cnt_q     <= '0;
               end
            end
            MD_RUN: begin
               cnt_q <= cnt_q + 1'b1;
               acc_q <= acc_step;
            end
            MD_DONE: begin
               hi_q <= hi_res;
               lo_q <= lo_res;
            end
            default: ;
         endcase
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: rtl/execute_stage.sv
// EX stage of the 5-stage MIPS core: forwarding muxes, single-cycle ALU,
// link override, the multiply/divide unit with its interlock, and the
// EX/MEM pipeline register.
module execute_stage
   import ex_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MD_CYCLES  = 32
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_halt,
   input  logic [DATA_WIDTH-1:0] i_rs_data,
   input  logic [DATA_WIDTH-1:0] i_rt_data,
   input  logic [DATA_WIDTH-1:0] i_imm_ext,
   input  logic [4:0]            i_shamt,
   input  logic [4:0]            i_rt,
   input  logic [4:0]            i_rd,
   input  logic [DATA_WIDTH-1:0] i_pc_plus_8,
   input  logic [1:0]            i_fwd_a_sel,
   input  logic [1:0]            i_fwd_b_sel,
   input  logic [DATA_WIDTH-1:0] i_fwd_mem_data,
   input  logic [DATA_WIDTH-1:0] i_fwd_wb_data,
   input  logic [3:0]            i_ctl_EX_alu_op,
   input  logic                  i_ctl_EX_alu_src,
   input  logic                  i_ctl_EX_shift_var,
   input  logic [1:0]            i_ctl_EX_reg_dst,
   input  logic                  i_ctl_EX_link,
   input  logic [2:0]            i_ctl_EX_md_op,
   input  logic                  i_ctl_MEM_mem_read,
   input  logic                  i_ctl_MEM_mem_write,
   input  logic                  i_ctl_MEM_unsigned,
   input  logic [1:0]            i_ctl_MEM_data_width,
   input  logic                  i_ctl_WB_mem_to_reg,
   input  logic                  i_ctl_WB_reg_write,
   output logic [DATA_WIDTH-1:0] o_ALU_result,
   output logic [DATA_WIDTH-1:0] o_data_to_write,
   output logic [4:0]            o_reg_dest,
   output logic                  o_ctl_MEM_mem_read,
   output logic                  o_ctl_MEM_mem_write,
   output logic                  o_ctl_MEM_unsigned,
   output logic [1:0]            o_ctl_MEM_data_width,
   output logic                  o_ctl_WB_mem_to_reg,
   output logic                  o_ctl_WB_reg_write,
   output logic                  o_stall,
   output logic                  o_md_busy
);

   localparam int W = DATA_WIDTH;

   logic signed [W-1:0] fwd_a_p0, fwd_b_p0, opnd_b_p0;
   logic [4:0]          shamt_p0;
   logic [W-1:0]        alu_p0, result_p0;
   logic [4:0]          dest_p0;
   logic [W-1:0]        md_hi, md_lo;
   logic                md_busy, md_start;

   logic [W-1:0]        alu_result_p1, data_to_write_p1;
   logic [4:0]          reg_dest_p1;
   logic                mem_read_p1, mem_write_p1, mem_unsigned_p1;
   logic [1:0]          mem_width_p1;
   logic                mem_to_reg_p1, reg_write_p1;

   // Operand forwarding and the immediate/shift-amount selection.
   always_comb begin
      case (i_fwd_a_sel)
         FWD_MEM: fwd_a_p0 = i_fwd_mem_data;
         FWD_WB:  fwd_a_p0 = i_fwd_wb_data;
         default: fwd_a_p0 = i_rs_data;
      endcase
      case (i_fwd_b_sel)
         FWD_MEM: fwd_b_p0 = i_fwd_mem_data;
         FWD_WB:  fwd_b_p0 = i_fwd_wb_data;
         default: fwd_b_p0 = i_rt_data;
      endcase
      opnd_b_p0 = i_ctl_EX_alu_src ? i_imm_ext : fwd_b_p0;
      shamt_p0  = i_ctl_EX_shift_var ? fwd_a_p0[4:0] : i_shamt;
   end

   // Single-cycle ALU; HI/LO reads come straight from the mul/div unit.
   always_comb begin
      case (i_ctl_EX_alu_op)
         ALU_ADD:  alu_p0 = fwd_a_p0 + opnd_b_p0;
         ALU_SUB:  alu_p0 = fwd_a_p0 - opnd_b_p0;
         ALU_AND:  alu_p0 = fwd_a_p0 & opnd_b_p0;
         ALU_OR:   alu_p0 = fwd_a_p0 | opnd_b_p0;
         ALU_XOR:  alu_p0 = fwd_a_p0 ^ opnd_b_p0;
         ALU_NOR:  alu_p0 = ~(fwd_a_p0 | opnd_b_p0);
         ALU_SLT:  alu_p0 = {{(W-1){1'b0}}, (fwd_a_p0 < opnd_b_p0)};
         ALU_SLTU: alu_p0 = {{(W-1){1'b0}}, ($unsigned(fwd_a_p0) < $unsigned(opnd_b_p0))};
         ALU_SLL:  alu_p0 = $unsigned(opnd_b_p0) << shamt_p0;
         ALU_SRL:  alu_p0 = $unsigned(opnd_b_p0) >> shamt_p0;
         ALU_SRA:  alu_p0 = $unsigned(opnd_b_p0 >>> shamt_p0);
         ALU_LUI:  alu_p0 = {opnd_b_p0[15:0], 16'h0000};
         ALU_MFHI: alu_p0 = md_hi;
         ALU_MFLO: alu_p0 = md_lo;
         default:  alu_p0 = '0;
      endcase
      result_p0 = i_ctl_EX_link ? i_pc_plus_8 : alu_p0;
   end

   // Destination register select; the unused code falls back to rt.
   always_comb begin
      case (i_ctl_EX_reg_dst)
         REG_DST_RD: dest_p0 = i_rd;
         REG_DST_RA: dest_p0 = 5'd31;
         default:    dest_p0 = i_rt;
      endcase
   end

   // A busy unit blocks new mul/div ops and HI/LO reads until it is idle again.
   assign o_stall   = md_busy & (is_md_op(i_ctl_EX_md_op) |
                                 (i_ctl_EX_alu_op == ALU_MFHI) |
                                 (i_ctl_EX_alu_op == ALU_MFLO));
   assign md_start  = is_md_op(i_ctl_EX_md_op) & ~o_stall;
   assign o_md_busy = md_busy;

   mul_div_unit #(
      .DATA_WIDTH (W),
      .MD_CYCLES  (MD_CYCLES)
   ) u_mul_div (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_halt    (i_halt),
      .start     (md_start),
      .op        (i_ctl_EX_md_op),
      .a         (fwd_a_p0),
      .b         (fwd_b_p0),
      .busy      (md_busy),
      .hi        (md_hi),
      .lo        (md_lo)
   );

   // EX/MEM register: load, insert a bubble on stall, hold on halt.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         alu_result_p1    <= '0;
         data_to_write_p1 <= '0;
         reg_dest_p1      <= '0;
         mem_read_p1      <= 1'b0;
         mem_write_p1     <= 1'b0;
         mem_unsigned_p1  <= 1'b0;
         mem_width_p1     <= '0;
         mem_to_reg_p1    <= 1'b0;
         reg_write_p1     <= 1'b0;
      end else if (!i_halt) begin
         if (o_stall) begin
            mem_read_p1     <= 1'b0;
            mem_write_p1    <= 1'b0;
            mem_unsigned_p1 <= 1'b0;
            mem_width_p1    <= '0;
            mem_to_reg_p1   <= 1'b0;
            reg_write_p1    <= 1'b0;
         end else begin
            alu_result_p1    <= result_p0;
            data_to_write_p1 <= fwd_b_p0;
            reg_dest_p1      <= dest_p0;
            mem_read_p1      <= i_ctl_MEM_mem_read;
            mem_write_p1     <= i_ctl_MEM_mem_write;
            mem_unsigned_p1  <= i_ctl_MEM_unsigned;
            mem_width_p1     <= i_ctl_MEM_data_width;
            mem_to_reg_p1    <= i_ctl_WB_mem_to_reg;
            reg_write_p1     <= i_ctl_WB_reg_write;
         end
      end
   end

   assign o_ALU_result         = alu_result_p1;
   assign o_data_to_write      = data_to_write_p1;
   assign o_reg_dest           = reg_dest_p1;
   assign o_ctl_MEM_mem_read   = mem_read_p1;
   assign o_ctl_MEM_mem_write  = mem_write_p1;
   assign o_ctl_MEM_unsigned   = mem_unsigned_p1;
   assign o_ctl_MEM_data_width = mem_width_p1;
   assign o_ctl_WB_mem_to_reg  = mem_to_reg_p1;
   assign o_ctl_WB_reg_write   = reg_write_p1;

endmodule
